// File: rtl/gpr_exec_unit.sv
// Execute core: GPR file, ALU with flags, iterative shift-add multiplier and SGPR.
// One instruction per valid/ready handshake; IDLE -> EXEC|MUL_RUN -> DONE -> IDLE.
module gpr_exec_unit #(
    parameter int DATA_W  = 16,
    parameter int REG_CNT = 32,
    parameter int MUL_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              done,
    output logic              err,
    output logic [3:0]        flags,
    output logic [DATA_W-1:0] sgpr,
    input  logic              host_we,
    input  logic [4:0]        host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXEC    = 2'd1;
    localparam logic [1:0] ST_MUL_RUN = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_OR      = 5'd5;
    localparam logic [4:0] OP_AND     = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;
    localparam logic [4:0] OP_XNOR    = 5'd8;
    localparam logic [4:0] OP_NAND    = 5'd9;
    localparam logic [4:0] OP_NOR     = 5'd10;
    localparam logic [4:0] OP_NOT     = 5'd11;

    logic [1:0]          state_reg;
    logic [31:0]         ir_reg;
    logic [DATA_W-1:0]   gpr_mem [REG_CNT];
    logic [DATA_W-1:0]   gpr_view [32];
    logic [DATA_W-1:0]   sgpr_reg;
    logic [3:0]          flags_reg;
    logic                done_reg;
    logic                err_reg;
    logic [5:0]          mul_cnt_reg;
    logic [2*DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0]   mplier_reg;
    logic [2*DATA_W-1:0] acc_reg;

    // Instruction fields come from the captured IR, never from the live instr bus.
    logic [4:0]        op_type;
    logic [4:0]        rdst;
    logic [4:0]        rsrc1;
    logic              imm_mode;
    logic [4:0]        rsrc2;
    logic [15:0]       isrc;
    logic [DATA_W-1:0] isrc_ext;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_illegal;
    logic              in_is_mul;

    assign op_type  = ir_reg[31:27];
    assign rdst     = ir_reg[26:22];
    assign rsrc1    = ir_reg[21:17];
    assign imm_mode = ir_reg[16];
    assign rsrc2    = ir_reg[15:11];
    assign isrc     = ir_reg[15:0];

    generate
        if (DATA_W > 16) begin : g_isrc_zext
            assign isrc_ext = {{(DATA_W-16){1'b0}}, isrc};
        end else begin : g_isrc_trunc
            assign isrc_ext = isrc[DATA_W-1:0];
        end
    endgenerate

    assign op_a       = gpr_view[rsrc1];
    assign op_b       = imm_mode ? isrc_ext : gpr_view[rsrc2];
    assign op_illegal = (op_type > OP_NOT) || (op_type == OP_MUL && MUL_EN == 0);
    assign in_is_mul  = (instr[31:27] == OP_MUL) && (MUL_EN != 0);

    // ALU for the single-cycle opcodes
    logic [DATA_W-1:0] alu_res;
    logic              alu_wr;
    logic              alu_flags_wr;
    logic              alu_carry;
    logic              alu_ovf;

    always_comb begin
        alu_res      = '0;
        alu_wr       = 1'b0;
        alu_flags_wr = 1'b0;
        alu_carry    = 1'b0;
        alu_ovf      = 1'b0;
        case (op_type)
            OP_MOVSGPR: begin
                alu_res = sgpr_reg;
                alu_wr  = 1'b1;
            end
            OP_MOV: begin
                alu_res = op_b;
                alu_wr  = 1'b1;
            end
            OP_ADD: begin
                {alu_carry, alu_res} = {1'b0, op_a} + {1'b0, op_b};
                alu_ovf      = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
                alu_wr       = 1'b1;
                alu_flags_wr = 1'b1;
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                {alu_carry, alu_res} = {1'b0, op_a} - {1'b0, op_b};
                alu_ovf      = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
                alu_wr       = 1'b1;
                alu_flags_wr = 1'b1;
            end
            OP_OR, OP_AND, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOT: begin
                case (op_type)
                    OP_OR:   alu_res = op_a | op_b;
                    OP_AND:  alu_res = op_a & op_b;
                    OP_XOR:  alu_res = op_a ^ op_b;
                    OP_XNOR: alu_res = ~(op_a ^ op_b);
                    OP_NAND: alu_res = ~(op_a & op_b);
                    OP_NOR:  alu_res = ~(op_a | op_b);
                    default: alu_res = ~op_a;
                endcase
                alu_wr       = 1'b1;
                alu_flags_wr = 1'b1;
            end
            default: begin
                alu_wr = 1'b0;
            end
        endcase
    end

    // Shift-add multiplier; operands are pulled from the register file on iteration 0.
    logic                mul_first;
    logic                mul_last;
    logic [2*DATA_W-1:0] mcand_cur;
    logic [DATA_W-1:0]   mplier_cur;
    logic [2*DATA_W-1:0] acc_cur;
    logic [2*DATA_W-1:0] acc_sum;

    assign mul_first  = (mul_cnt_reg == 6'd0);
    assign mul_last   = (mul_cnt_reg == 6'(DATA_W-1));
    assign mcand_cur  = mul_first ? {{DATA_W{1'b0}}, op_a} : mcand_reg;
    assign mplier_cur = mul_first ? op_b : mplier_reg;
    assign acc_cur    = mul_first ? '0 : acc_reg;
    assign acc_sum    = acc_cur + (mplier_cur[0] ? mcand_cur : '0);

    // Register file write ports: core in EXEC/MUL_RUN, host only in IDLE, so never both.
    logic              core_we;
    logic [DATA_W-1:0] core_wdata;
    logic              host_wr;
    logic [REG_CNT-1:0] core_sel;
    logic [REG_CNT-1:0] host_sel;

    assign core_we    = (state_reg == ST_EXEC && alu_wr && !op_illegal)
                     || (state_reg == ST_MUL_RUN && mul_last);
    assign core_wdata = (state_reg == ST_MUL_RUN) ? acc_sum[DATA_W-1:0] : alu_res;
    assign host_wr    = (state_reg == ST_IDLE) && host_we;

    genvar gi;
    generate
        for (gi = 0; gi < REG_CNT; gi++) begin : g_wsel
            assign core_sel[gi] = core_we && (rdst == 5'(gi));
            assign host_sel[gi] = host_wr && (host_waddr == 5'(gi));
        end
        for (gi = 0; gi < 32; gi++) begin : g_view
            if (gi < REG_CNT) begin : g_impl
                assign gpr_view[gi] = gpr_mem[gi];
            end else begin : g_absent
                assign gpr_view[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                gpr_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_CNT; i++) begin
                if (core_sel[i]) begin
                    gpr_mem[i] <= core_wdata;
                end else if (host_sel[i]) begin
                    gpr_mem[i] <= host_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgpr_reg  <= '0;
            flags_reg <= '0;
        end else if (state_reg == ST_EXEC && alu_flags_wr && !op_illegal) begin
            flags_reg <= {alu_res[DATA_W-1], (alu_res == '0), alu_carry, alu_ovf};
        end else if (state_reg == ST_MUL_RUN && mul_last) begin
            sgpr_reg  <= acc_sum[2*DATA_W-1:DATA_W];
            flags_reg <= {acc_sum[2*DATA_W-1], (acc_sum == '0), 1'b0,
                          (acc_sum[2*DATA_W-1:DATA_W] != '0)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            ir_reg      <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            mul_cnt_reg <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        ir_reg      <= instr;
                        mul_cnt_reg <= '0;
                        state_reg   <= in_is_mul ? ST_MUL_RUN : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    done_reg  <= 1'b1;
                    err_reg   <= op_illegal;
                    state_reg <= ST_DONE;
                end
                ST_MUL_RUN: begin
                    mcand_reg   <= mcand_cur << 1;
                    mplier_reg  <= mplier_cur >> 1;
                    acc_reg     <= acc_sum;
                    mul_cnt_reg <= mul_cnt_reg + 6'd1;
                    if (mul_last) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign done      = done_reg;
    assign err       = err_reg;
    assign flags     = flags_reg;
    assign sgpr      = sgpr_reg;
    assign dbg_rdata = gpr_view[dbg_raddr];

endmodule

// File: tb/tb_gpr_exec_unit.sv
// Randomized and directed bench for gpr_exec_unit against an arithmetic reference model.
module tb_gpr_exec_unit;

    localparam int W = 16;
    localparam longint unsigned MASK = (64'd1 << W) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic          done;
    logic          err;
    logic [3:0]    flags;
    logic [W-1:0]  sgpr;
    logic          host_we;
    logic [4:0]    host_waddr;
    logic [W-1:0]  host_wdata;
    logic [4:0]    dbg_raddr;
    logic [W-1:0]  dbg_rdata;

    gpr_exec_unit #(.DATA_W(W), .REG_CNT(32), .MUL_EN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .done       (done),
        .err        (err),
        .flags      (flags),
        .sgpr       (sgpr),
        .host_we    (host_we),
        .host_waddr (host_waddr),
        .host_wdata (host_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state
    longint unsigned m_gpr [32];
    longint unsigned m_sgpr;
    logic [3:0]      m_flags;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input bit imm,
                                        input logic [15:0] low);
        return {5'(op), 5'(rd), 5'(rs1), imm, low};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 0;
        m_sgpr  = 0;
        m_flags = 4'b0000;
    endtask

    task automatic model_exec(input logic [31:0] ins, output bit illegal, output bit is_mul);
        int op, rd;
        longint unsigned a, b, r, p, hi;
        bit c, v, sa, sb, sr;
        op = int'(ins[31:27]);
        rd = int'(ins[26:22]);
        a  = m_gpr[ins[21:17]];
        b  = ins[16] ? (longint'(ins[15:0]) & MASK) : m_gpr[ins[15:11]];
        illegal = (op > 11);
        is_mul  = (op == 4);
        c = 0; v = 0; r = 0;
        sa = a[W-1];
        sb = b[W-1];
        if (illegal) begin
            // no architectural effect
        end else if (op == 0) begin
            m_gpr[rd] = m_sgpr;
        end else if (op == 1) begin
            m_gpr[rd] = b;
        end else if (op == 4) begin
            p  = a * b;
            hi = p >> W;
            m_gpr[rd] = p & MASK;
            m_sgpr    = hi;
            m_flags   = {p[2*W-1], (p == 0), 1'b0, (hi != 0)};
        end else begin
            case (op)
                2: begin r = a + b; c = r[W]; r = r & MASK; end
                3: begin c = (a < b); r = (a - b) & MASK; end
                5: r = a | b;
                6: r = a & b;
                7: r = a ^ b;
                8: r = ~(a ^ b) & MASK;
                9: r = ~(a & b) & MASK;
                10: r = ~(a | b) & MASK;
                default: r = ~a & MASK;
            endcase
            sr = r[W-1];
            if (op == 2) v = (sa == sb) && (sr != sa);
            if (op == 3) v = (sa != sb) && (sr != sa);
            m_gpr[rd] = r;
            m_flags   = {sr, (r == 0), c, v};
        end
    endtask

    task automatic read_gpr(input int addr, output logic [W-1:0] val);
        dbg_raddr = 5'(addr);
        #1;
        val = dbg_rdata;
    endtask

    task automatic expect_gpr(input string tag, input int addr, input logic [W-1:0] exp);
        logic [W-1:0] v;
        read_gpr(addr, v);
        check_val(tag, v, exp);
    endtask

    task automatic host_load(input int addr, input logic [W-1:0] data);
        host_we    = 1'b1;
        host_waddr = 5'(addr);
        host_wdata = data;
        @(posedge clk); #1;
        host_we = 1'b0;
        m_gpr[addr] = data;
    endtask

    task automatic sweep(input string tag);
        logic [W-1:0] v;
        for (int i = 0; i < 32; i++) begin
            read_gpr(i, v);
            check_val(tag, v, m_gpr[i][W-1:0]);
        end
        @(posedge clk); #1;
    endtask

    // Issues one instruction (optionally with a host write on the accept edge) and checks retirement.
    task automatic run_instr(input logic [31:0] ins, input bit with_host, input int haddr,
                             input logic [W-1:0] hdata, input bit noisy);
        bit ill, mul;
        int cyc, rd;
        logic [W-1:0] v;
        rd = int'(ins[26:22]);
        check_val("ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        instr    = ins;
        if (with_host) begin
            host_we    = 1'b1;
            host_waddr = 5'(haddr);
            host_wdata = hdata;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        host_we  = 1'b0;
        instr    = $urandom;
        if (with_host) m_gpr[haddr] = hdata;
        model_exec(ins, ill, mul);
        check_val("ready_low_busy", in_ready, 1'b0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (noisy) begin
                in_valid   = 1'($urandom_range(0, 1));
                instr      = $urandom;
                host_we    = 1'($urandom_range(0, 1));
                host_waddr = 5'($urandom);
                host_wdata = W'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        host_we  = 1'b0;
        check_val("latency", cyc, mul ? W : 1);
        check_val("err", err, ill);
        check_val("flags", flags, m_flags);
        check_val("sgpr", sgpr, m_sgpr[W-1:0]);
        read_gpr(rd, v);
        check_val("rdst", v, m_gpr[rd][W-1:0]);
        $display("instr=%08h op=%0d rd=%0d lat=%0d err=%0b res=%04h flags=%04b sgpr=%04h",
                 ins, ins[31:27], rd, cyc, err, v, flags, sgpr);
        @(posedge clk); #1;
        check_val("done_single_pulse", done, 1'b0);
        check_val("ready_after_done", in_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] ins;
        int op;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        instr      = '0;
        host_we    = 1'b0;
        host_waddr = '0;
        host_wdata = '0;
        dbg_raddr  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_done", done, 1'b0);
        check_val("rst_err", err, 1'b0);
        check_val("rst_ready", in_ready, 1'b1);
        check_val("rst_flags", flags, 4'b0000);
        check_val("rst_sgpr", sgpr, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sweep("rst_gpr");

        for (int i = 0; i < 32; i++) host_load(i, 16'd2);

        // ADD immediate
        run_instr(enc(2, 0, 2, 1, 16'd4), 0, 0, '0, 0);
        expect_gpr("tp_add_imm", 0, 16'd6);
        check_val("tp_add_imm_flags", flags, 4'b0000);

        // ADD of zeros, then MOV immediate leaves flags alone
        host_load(0, 16'h0000);
        host_load(1, 16'h0000);
        run_instr(enc(2, 2, 0, 0, {5'd1, 11'd0}), 0, 0, '0, 0);
        check_val("tp_zero_flags", flags, 4'b0100);
        run_instr(enc(1, 4, 0, 1, 16'd55), 0, 0, '0, 0);
        expect_gpr("tp_movi", 4, 16'd55);
        check_val("tp_movi_flags", flags, 4'b0100);

        // Signed overflow with carry, then borrow
        host_load(0, 16'h8000);
        host_load(1, 16'h8002);
        run_instr(enc(2, 2, 0, 0, {5'd1, 11'd0}), 0, 0, '0, 0);
        expect_gpr("tp_add_ovf", 2, 16'h0002);
        check_val("tp_add_ovf_flags", flags, 4'b0011);
        host_load(0, 16'h0001);
        host_load(1, 16'h0002);
        run_instr(enc(3, 3, 0, 0, {5'd1, 11'd0}), 0, 0, '0, 0);
        expect_gpr("tp_sub", 3, 16'hFFFF);
        check_val("tp_sub_flags", flags, 4'b1010);

        // Multiply into the high half, then move it out of SGPR
        host_load(0, 16'h0100);
        host_load(1, 16'h0300);
        run_instr(enc(4, 6, 0, 0, {5'd1, 11'd0}), 0, 0, '0, 1);
        expect_gpr("tp_mul_lo", 6, 16'h0000);
        check_val("tp_mul_sgpr", sgpr, 16'h0003);
        check_val("tp_mul_flags", flags, 4'b0001);
        run_instr(enc(0, 5, 0, 0, 16'd0), 0, 0, '0, 0);
        expect_gpr("tp_movsgpr", 5, 16'd3);

        // Illegal opcode with bus noise while busy
        run_instr(enc(31, 7, 1, 0, 16'hFFFF), 0, 0, '0, 1);
        sweep("illegal_gpr");

        // Host write on the accept edge is seen by the instruction; rsrc==rdst
        run_instr(enc(2, 9, 9, 1, 16'd1), 1, 9, 16'h7FFF, 0);
        check_val("host_accept_flags", flags, 4'b1001);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            op  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 31)) : int'($urandom_range(0, 11));
            ins = enc(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 16'($urandom));
            if ($urandom_range(0, 3) == 0)
                host_load(int'($urandom_range(0, 31)), W'($urandom));
            run_instr(ins, 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 31)),
                      W'($urandom), 1'($urandom_range(0, 1)));
            if (n % 20 == 19) sweep("rand_sweep");
        end

        // Reset in the middle of a multiply
        host_load(0, 16'h1234);
        host_load(1, 16'h0055);
        in_valid = 1'b1;
        instr    = enc(4, 3, 0, 0, {5'd1, 11'd0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
            check_val("mul_no_early_done", done, 1'b0);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("midrst_ready", in_ready, 1'b1);
        check_val("midrst_done", done, 1'b0);
        check_val("midrst_flags", flags, 4'b0000);
        check_val("midrst_sgpr", sgpr, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(posedge clk); #1;
            check_val("postrst_no_done", done, 1'b0);
        end
        sweep("postrst_gpr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
